// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width; it must hold WIDTH-1, and is never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w < 32'd2) return 32'd1;
    return 32'($clog2(w));
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module div_restore_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] partial_rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             in_bit_i,
  output logic [WIDTH-1:0] next_rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // The trial value carries one extra bit, so the compare never overflows.
  // When it fits, the difference is below the divisor and fits in WIDTH bits.
  always_comb begin
    trial      = {partial_rem_i, in_bit_i};
    diff       = trial[WIDTH-1:0] - divisor_i;
    q_bit_o    = (trial >= {1'b0, divisor_i});
    next_rem_o = q_bit_o ? diff : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider that resolves one quotient bit per clock.
// A start/done handshake frames each operation; a zero divisor completes immediately.
module seq_restoring_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_c;
  logic             zero_div_c;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  assign accept_c   = start && (state_q != RUN);
  assign zero_div_c = (divisor == '0);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem_i (rem_q),
    .divisor_i     (dvs_q),
    .in_bit_i      (dvd_q[WIDTH-1]),
    .next_rem_o    (step_rem),
    .q_bit_o       (step_qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE accepts a new request just like IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept_c) state_d = zero_div_c ? DONE : RUN;
        else          state_d = IDLE;
      end
      RUN:     if (cnt_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status next values.
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    if (state_q == RUN) begin
      // Dividend register doubles as the quotient: bits shift out MSB first, quotient bits enter at the LSB.
      rem_d = step_rem;
      dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    end else if (accept_c) begin
      dvs_d = divisor;
      dbz_d = zero_div_c;
      if (zero_div_c) begin
        dvd_d = '1;
        rem_d = dividend;
      end else begin
        dvd_d = dividend;
        rem_d = '0;
        cnt_d = CW'(WIDTH - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient    = dvd_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
